// File: rtl/video_timing_if.sv
// Raster timing bundle carried from video_timing_gen to the pixel pipeline / TMDS encoders.
// fc_out is present only when VSG_FRAME_COUNT_EN is defined.
interface video_timing_if #(
  parameter int unsigned HW = 11,
  parameter int unsigned VW = 10,
  parameter int unsigned FW = 6
);
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          hs_out;
  logic          vs_out;
  logic          ad_out;
  logic          nf_out;
`ifdef VSG_FRAME_COUNT_EN
  logic [FW-1:0] fc_out;
`endif

`ifdef VSG_FRAME_COUNT_EN
  modport master (output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out);
  modport slave  (input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out);
`else
  modport master (output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out);
  modport slave  (input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out);
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: counters, syncs, active-draw and new-frame strobe.
// Optional frame counter (fc_out) enabled by defining VSG_FRAME_COUNT_EN.
module video_timing_gen #(
  parameter int unsigned ACTIVE_H = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned ACTIVE_V = 720,
  parameter int unsigned V_FRONT  = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned FPS      = 60,
  parameter int unsigned SYNC_POL = 1,
  localparam int unsigned H_TOTAL = ACTIVE_H + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL = ACTIVE_V + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL),
  localparam int unsigned FW      = $clog2(FPS)
) (
  input  logic           clk_in,
  input  logic           rst_in,
  video_timing_if.master vid_if
);

  if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 || FPS < 2) begin : g_bad_param
    $error("video_timing_gen: porch/sync widths must be nonzero and FPS >= 2");
  end

  localparam logic [HW-1:0] HMax     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HActive  = HW'(ACTIVE_H);
  localparam logic [HW-1:0] HsStart  = HW'(ACTIVE_H + H_FRONT);
  localparam logic [HW-1:0] HsEnd    = HW'(ACTIVE_H + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VMax     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VActive  = VW'(ACTIVE_V);
  localparam logic [VW-1:0] VsStart  = VW'(ACTIVE_V + V_FRONT);
  localparam logic [VW-1:0] VsEnd    = VW'(ACTIVE_V + V_FRONT + V_SYNC);
  localparam logic          SyncOn   = (SYNC_POL != 0);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;
  logic          h_wrap, v_wrap;

  // Decode from the next counter values so every output lines up with its coordinates.
  always_comb begin
    h_wrap   = (hcount_q == HMax);
    v_wrap   = (vcount_q == VMax);
    hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
    end
    ad_d = (hcount_d < HActive) && (vcount_d < VActive);
    hs_d = ((hcount_d >= HsStart) && (hcount_d < HsEnd)) ? SyncOn : ~SyncOn;
    vs_d = ((vcount_d >= VsStart) && (vcount_d < VsEnd)) ? SyncOn : ~SyncOn;
    nf_d = (hcount_d == HActive) && (vcount_d == VActive);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcount_q <= HMax;
      vcount_q <= VMax;
      hs_q     <= ~SyncOn;
      vs_q     <= ~SyncOn;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
    end
  end

  assign vid_if.hcount_out = hcount_q;
  assign vid_if.vcount_out = vcount_q;
  assign vid_if.hs_out     = hs_q;
  assign vid_if.vs_out     = vs_q;
  assign vid_if.ad_out     = ad_q;
  assign vid_if.nf_out     = nf_q;

`ifdef VSG_FRAME_COUNT_EN
  localparam logic [FW-1:0] FMax = FW'(FPS - 1);

  logic [FW-1:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FMax) ? '0 : fc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign vid_if.fc_out = fc_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with small raster parameters; both sync polarities run in lockstep
// against a position-from-elapsed-time reference model.
module tb_video_timing_gen;

  localparam int AH = 8, HF = 2, HS = 2, HB = 2;
  localparam int AV = 4, VF = 1, VS = 1, VB = 1;
  localparam int FPS = 60;
  localparam int HT = AH + HF + HS + HB;
  localparam int VT = AV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int NF_T = AV * HT + AH;
  localparam int unsigned HW = $clog2(HT);
  localparam int unsigned VW = $clog2(VT);
  localparam int unsigned FW = $clog2(FPS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_if #(.HW(HW), .VW(VW), .FW(FW)) vif_p ();
  video_timing_if #(.HW(HW), .VW(VW), .FW(FW)) vif_n ();

  video_timing_gen #(
    .ACTIVE_H(AH), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .ACTIVE_V(AV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FPS(FPS), .SYNC_POL(1)
  ) u_dut_p (
    .clk_in(clk),
    .rst_in(rst),
    .vid_if(vif_p)
  );

  video_timing_gen #(
    .ACTIVE_H(AH), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .ACTIVE_V(AV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FPS(FPS), .SYNC_POL(0)
  ) u_dut_n (
    .clk_in(clk),
    .rst_in(rst),
    .vid_if(vif_n)
  );

  int tests = 0;
  int fails = 0;
  int t = -1;  // cycles since reset release; -1 while the reset state is being held
  int ad_cnt = 0, hs_cnt = 0, vs_cnt = 0, nf_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic check_all();
    int h, v, fc;
    int ad, hw, vw, nf;
    if (t < 0) begin
      h = HT - 1; v = VT - 1; ad = 0; hw = 0; vw = 0; nf = 0; fc = 0;
    end else begin
      h  = t % HT;
      v  = (t / HT) % VT;
      ad = int'((h < AH) && (v < AV));
      hw = int'((h >= AH + HF) && (h < AH + HF + HS));
      vw = int'((v >= AV + VF) && (v < AV + VF + VS));
      nf = int'((h == AH) && (v == AV));
      fc = (t < NF_T) ? 0 : ((t - NF_T) / FRAME + 1) % FPS;
    end
    check_eq("hcount", 32'(vif_p.hcount_out), h);
    check_eq("vcount", 32'(vif_p.vcount_out), v);
    check_eq("ad", 32'(vif_p.ad_out), ad);
    check_eq("nf", 32'(vif_p.nf_out), nf);
    check_eq("hs_pos", 32'(vif_p.hs_out), hw);
    check_eq("vs_pos", 32'(vif_p.vs_out), vw);
    check_eq("hs_neg", 32'(vif_n.hs_out), 1 - hw);
    check_eq("vs_neg", 32'(vif_n.vs_out), 1 - vw);
    check_eq("hcount_neg", 32'(vif_n.hcount_out), h);
`ifdef VSG_FRAME_COUNT_EN
    check_eq("fc", 32'(vif_p.fc_out), fc);
`endif
    // Per-frame totals, counted from the DUT outputs over each complete frame.
    if (t < 0) begin
      ad_cnt = 0; hs_cnt = 0; vs_cnt = 0; nf_cnt = 0;
    end else begin
      ad_cnt += int'(vif_p.ad_out);
      hs_cnt += int'(vif_p.hs_out);
      vs_cnt += int'(vif_p.vs_out);
      nf_cnt += int'(vif_p.nf_out);
      if (t % FRAME == FRAME - 1) begin
        check_eq("frame_ad_total", ad_cnt, AH * AV);
        check_eq("frame_hs_total", hs_cnt, HS * VT);
        check_eq("frame_vs_total", vs_cnt, VS * HT);
        check_eq("frame_nf_total", nf_cnt, 1);
        ad_cnt = 0; hs_cnt = 0; vs_cnt = 0; nf_cnt = 0;
      end
    end
  endtask

  // Apply rst for one edge, advance the model, then check on the falling edge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    if (r) t = -1;
    else   t = t + 1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    repeat (3) step(1'b1);
    // Long unbroken run: 61 frames brings the frame count back round to 1.
    for (int i = 0; i < 61 * FRAME + 20; i++) step(1'b0);

    // Abort mid-frame at a fixed position, then restart cleanly.
    n = 0;
    while (!((t % HT == 5) && ((t / HT) % VT == 2)) && n < 2 * FRAME) begin
      step(1'b0);
      n++;
    end
    check_eq("midframe_pos_reached", 32'(n < 2 * FRAME), 1);
    step(1'b1);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0);

    // Random reset pulses of random length scattered through free-running operation.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        n = int'($urandom_range(1, 4));
        for (int k = 0; k < n; k++) step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
